sample_slot_scheduler: RTL and testbench

Sequences the per-frame audio sample slot between two sample sources: source A (music player, dry) and source B (echo, wet). On each codec frame strobe it issues one request to the sources, collects each source's sample with a bounded wait, combines the samples according to the selected mix mode, and presents one output sample with a valid pulse. It sits between the codec's `new_frame` and the codec/wave-display sample inputs, replacing the fixed music_player → echo → codec wiring.

---
 rtl/sample_slot_scheduler.sv | 130 +++++++++++++
 tb/tb_sample_slot_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_slot_scheduler.sv
// Per-frame sample slot sequencer: requests both sources, collects with bounded wait, mixes, emits one sample.
// Optional build macro SAMPLE_SLOT_SAT_EN: saturate SUM mode instead of averaging.
module sample_slot_scheduler #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_frame,
  output logic        req,
  input  logic [15:0] a_sample,
  input  logic        a_ready,
  input  logic [15:0] b_sample,
  input  logic        b_ready,
  input  logic        mode_next,
  output logic [1:0]  mode,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic [1:0]  missed,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_MIX, S_OUT} state_t;
  typedef enum logic [1:0] {M_DRY, M_WET, M_SUM, M_MUTE} mode_t;

  state_t             state, state_nx;
  mode_t              mode_q, frame_mode;
  logic               got_a, got_b;
  logic [15:0]        cap_a, cap_b;
  logic [CNT_W-1:0]   cnt;

  logic               cap_en, got_a_now, got_b_now, need_a, need_b, done, timed_out;
  logic signed [16:0] sum17;
  logic [15:0]        sum16, mix_val;

  assign mode      = mode_q;
  assign cap_en    = (state == S_REQ) || (state == S_WAIT);
  assign got_a_now = got_a || (cap_en && a_ready);
  assign got_b_now = got_b || (cap_en && b_ready);
  assign need_a    = (frame_mode == M_DRY) || (frame_mode == M_SUM);
  assign need_b    = (frame_mode == M_WET) || (frame_mode == M_SUM);
  // a ready arriving on the completion cycle counts toward completion
  assign done      = (!need_a || got_a_now) && (!need_b || got_b_now);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx     = state;
    req          = 1'b0;
    sample_valid = 1'b0;
    unique case (state)
      S_IDLE: if (new_frame) state_nx = S_REQ;
      S_REQ: begin
        req      = 1'b1;
        state_nx = S_WAIT;
      end
      S_WAIT: if (done || timed_out) state_nx = S_MIX;
      S_MIX:  state_nx = S_OUT;
      S_OUT: begin
        sample_valid = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // uncaptured samples are held at zero, so they substitute as silence
  always_comb begin
    sum17 = $signed({cap_a[15], cap_a}) + $signed({cap_b[15], cap_b});
`ifdef SAMPLE_SLOT_SAT_EN
    if (sum17[16] != sum17[15]) sum16 = sum17[16] ? 16'h8000 : 16'h7FFF;
    else                        sum16 = sum17[15:0];
`else
    sum16 = sum17[16:1];
`endif
    mix_val = '0;
    unique case (frame_mode)
      M_DRY:  mix_val = cap_a;
      M_WET:  mix_val = cap_b;
      M_SUM:  mix_val = sum16;
      M_MUTE: mix_val = '0;
      default: mix_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mode_q     <= M_DRY;
      frame_mode <= M_DRY;
      got_a      <= 1'b0;
      got_b      <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      cnt        <= '0;
      sample_out <= '0;
      missed     <= '0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nx;
      if (mode_next) mode_q <= mode_t'(mode_q + 2'd1);
      if (new_frame && state != S_IDLE) overrun <= 1'b1;

      if (state == S_IDLE && new_frame) begin
        frame_mode <= mode_q;
        got_a      <= 1'b0;
        got_b      <= 1'b0;
        cap_a      <= '0;
        cap_b      <= '0;
        cnt        <= '0;
      end

      if (cap_en && a_ready && !got_a) begin
        cap_a <= a_sample;
        got_a <= 1'b1;
      end
      if (cap_en && b_ready && !got_b) begin
        cap_b <= b_sample;
        got_b <= 1'b1;
      end

      if (state == S_WAIT) cnt <= cnt + 1'b1;

      if (state == S_MIX) begin
        sample_out <= mix_val;
        missed     <= {need_b && !got_b, need_a && !got_a};
      end
    end
  end

endmodule

// File: tb/tb_sample_slot_scheduler.sv
// Bench for sample_slot_scheduler: directed vector table, hand sequences, randomized frames vs. a frame-level model.
module tb_sample_slot_scheduler;

  localparam int TO = 16;

`ifdef SAMPLE_SLOT_SAT_EN
  localparam logic [15:0] SUM_HI   = 16'h7FFF;
  localparam logic [15:0] SUM_SM   = 16'h0002;
  localparam logic [15:0] SUM_HALF = 16'h0100;
  localparam logic [15:0] SUM_NEG  = 16'h8000;
`else
  localparam logic [15:0] SUM_HI   = 16'h7000;
  localparam logic [15:0] SUM_SM   = 16'h0001;
  localparam logic [15:0] SUM_HALF = 16'h0080;
  localparam logic [15:0] SUM_NEG  = 16'hBFFF;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        new_frame = 1'b0;
  logic        req;
  logic [15:0] a_sample = '0;
  logic        a_ready = 1'b0;
  logic [15:0] b_sample = '0;
  logic        b_ready = 1'b0;
  logic        mode_next = 1'b0;
  logic [1:0]  mode;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic [1:0]  missed;
  logic        overrun;

  int          checks = 0;
  int          failures = 0;
  logic [1:0]  exp_mode = 2'd0;

  sample_slot_scheduler #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .new_frame(new_frame), .req(req),
    .a_sample(a_sample), .a_ready(a_ready), .b_sample(b_sample), .b_ready(b_ready),
    .mode_next(mode_next), .mode(mode), .sample_out(sample_out),
    .sample_valid(sample_valid), .missed(missed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  m;
    int          ta, tb;
    logic [15:0] va, vb;
    bit          dup;
    int          mn;
    logic [15:0] eo;
    logic [1:0]  em;
    int          evc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic [1:0] m, input int ta, input int tb,
                              input logic [15:0] va, input logic [15:0] vb, input bit dup,
                              input int mn, input logic [15:0] eo, input logic [1:0] em, input int evc);
    vec_t v;
    v.nm = nm; v.m = m; v.ta = ta; v.tb = tb; v.va = va; v.vb = vb; v.dup = dup;
    v.mn = mn; v.eo = eo; v.em = em; v.evc = evc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: cycle numbers are relative to the new_frame cycle (0); req is cycle 1,
  // the wait window covers cycles 2..TO+1, result visible two cycles after the completion cycle.
  function automatic void model(input logic [1:0] m, input int ta, input int tb,
                                input logic [15:0] va, input logic [15:0] vb,
                                output logic [15:0] o, output logic [1:0] ms, output int vc);
    bit need_a, need_b, ok_a, ok_b, cap_a, cap_b;
    int last, d, sa, sb, s;
    need_a = (m == 2'd0) || (m == 2'd2);
    need_b = (m == 2'd1) || (m == 2'd2);
    last   = TO + 1;
    ok_a   = (ta >= 1) && (ta <= last);
    ok_b   = (tb >= 1) && (tb <= last);
    if (m == 2'd3) d = 2;
    else if ((!need_a || ok_a) && (!need_b || ok_b)) begin
      d = 2;
      if (need_a && ta > d) d = ta;
      if (need_b && tb > d) d = tb;
    end else d = last;
    cap_a = (ta >= 1) && (ta <= d);
    cap_b = (tb >= 1) && (tb <= d);
    sa = cap_a ? int'($signed(va)) : 0;
    sb = cap_b ? int'($signed(vb)) : 0;
    s  = sa + sb;
`ifdef SAMPLE_SLOT_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`else
    s = s >>> 1;
`endif
    case (m)
      2'd0: o = 16'(sa);
      2'd1: o = 16'(sb);
      2'd2: o = 16'(s);
      default: o = 16'h0000;
    endcase
    ms = {need_b && !cap_b, need_a && !cap_a};
    vc = d + 2;
  endfunction

  task automatic run_frame(input logic [1:0] m, input int ta, input int tb,
                           input logic [15:0] va, input logic [15:0] vb, input bit dup,
                           input int nf2, input int mn,
                           output logic [15:0] o, output logic [1:0] ms,
                           output int vc, output int nv, output int rc);
    while (exp_mode != m) begin
      mode_next = 1'b1;
      step();
      mode_next = 1'b0;
      exp_mode++;
    end
    chk("mode_set", 32'(mode), 32'(exp_mode));
    vc = -1; nv = 0; rc = -1; o = '0; ms = '0;
    for (int c = 0; c < 24; c++) begin
      if (sample_valid) begin
        nv++;
        if (vc < 0) begin vc = c; o = sample_out; ms = missed; end
      end
      if (req && rc < 0) rc = c;
      new_frame = (c == 0) || (c == nf2);
      mode_next = (c == mn);
      if (c == mn) exp_mode++;
      a_ready  = (c == ta) || (dup && ta >= 0 && c == ta + 1);
      a_sample = (c == ta) ? va : 16'($urandom);
      b_ready  = (c == tb);
      b_sample = (c == tb) ? vb : 16'($urandom);
      step();
    end
    new_frame = 1'b0; mode_next = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
  endtask

  logic [15:0] o, eo;
  logic [1:0]  ms, em;
  int          vc, nv, rc, evc;

  initial begin
    tbl.push_back(mk("dry_basic",  2'd0,  4, -1, 16'h1234, 16'h5555, 0, -1, 16'h1234, 2'b00,  6));
    tbl.push_back(mk("sum_pos",    2'd2,  3,  5, 16'h7000, 16'h7000, 0, -1, SUM_HI,   2'b00,  7));
    tbl.push_back(mk("sum_small",  2'd2,  2,  2, 16'hFFFE, 16'h0004, 0, -1, SUM_SM,   2'b00,  4));
    tbl.push_back(mk("wet_timeout",2'd1,  3, -1, 16'h1111, 16'h0000, 0, -1, 16'h0000, 2'b10, 19));
    tbl.push_back(mk("mute",       2'd3,  2,  2, 16'h1111, 16'h2222, 0, -1, 16'h0000, 2'b00,  4));
    tbl.push_back(mk("dry_dup",    2'd0,  3, -1, 16'hABCD, 16'h0000, 1, -1, 16'hABCD, 2'b00,  5));
    tbl.push_back(mk("sum_b_miss", 2'd2,  2, -1, 16'h0100, 16'h0000, 0, -1, SUM_HALF, 2'b10, 19));
    tbl.push_back(mk("wet_last",   2'd1, -1, 17, 16'h0000, 16'h2468, 0, -1, 16'h2468, 2'b00, 19));
    tbl.push_back(mk("dry_late",   2'd0, 18, -1, 16'h3333, 16'h0000, 0, -1, 16'h0000, 2'b01, 19));
    tbl.push_back(mk("sum_neg",    2'd2,  4,  4, 16'h8000, 16'hFFFF, 0, -1, SUM_NEG,  2'b00,  6));
    tbl.push_back(mk("dry_mn_wait",2'd0,  5, -1, 16'h0BEE, 16'h0000, 0,  3, 16'h0BEE, 2'b00,  7));
    tbl.push_back(mk("dry_mn_edge",2'd0,  2, -1, 16'h0C0C, 16'h0000, 0,  0, 16'h0C0C, 2'b00,  4));

    #2;
    chk("rst_req", 32'(req), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_out", 32'(sample_out), 0);
    chk("rst_mode", 32'(mode), 0);
    chk("rst_missed", 32'(missed), 0);
    chk("rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      run_frame(tbl[i].m, tbl[i].ta, tbl[i].tb, tbl[i].va, tbl[i].vb, tbl[i].dup, -1, tbl[i].mn,
                o, ms, vc, nv, rc);
      chk({tbl[i].nm, "_out"}, 32'(o), 32'(tbl[i].eo));
      chk({tbl[i].nm, "_missed"}, 32'(ms), 32'(tbl[i].em));
      chk({tbl[i].nm, "_vcycle"}, vc, tbl[i].evc);
      chk({tbl[i].nm, "_nvalid"}, nv, 1);
      chk({tbl[i].nm, "_reqcycle"}, rc, 1);
    end
    chk("mode_after_edge", 32'(mode), 1);
    chk("overrun_clear", 32'(overrun), 0);

    // second new_frame two cycles into a frame
    run_frame(2'd0, 4, -1, 16'h4321, 16'h0000, 0, 2, -1, o, ms, vc, nv, rc);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_nvalid", nv, 1);
    chk("ovr_out", 32'(o), 32'h4321);

    // async reset while waiting for sources
    new_frame = 1'b1; step(); new_frame = 1'b0; step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req), 0);
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_out", 32'(sample_out), 0);
    chk("mid_rst_mode", 32'(mode), 0);
    chk("mid_rst_missed", 32'(missed), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    exp_mode = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    run_frame(2'd0, 3, -1, 16'h7777, 16'h0000, 0, -1, -1, o, ms, vc, nv, rc);
    chk("post_rst_req", rc, 1);
    chk("post_rst_out", 32'(o), 32'h7777);

    for (int i = 0; i < 5; i++) begin
      mode_next = 1'b1; step(); mode_next = 1'b0;
    end
    exp_mode = 2'd1;
    chk("mode_x5", 32'(mode), 1);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  m;
      int          ta, tb;
      logic [15:0] va, vb;
      bit          dup;
      m   = 2'($urandom_range(0, 3));
      ta  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(2, 20));
      tb  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(2, 20));
      va  = 16'($urandom);
      vb  = 16'($urandom);
      dup = 1'($urandom);
      model(m, ta, tb, va, vb, eo, em, evc);
      run_frame(m, ta, tb, va, vb, dup, -1, -1, o, ms, vc, nv, rc);
      chk($sformatf("rnd%0d_out", i), 32'(o), 32'(eo));
      chk($sformatf("rnd%0d_missed", i), 32'(ms), 32'(em));
      chk($sformatf("rnd%0d_vcycle", i), vc, evc);
      chk($sformatf("rnd%0d_nvalid", i), nv, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
